// File: rtl/mem_xfer_ctrl.sv
// mem_xfer_ctrl: SRAM transfer sequencer feeding the MDR (D/Load pair).
// Runs one read or write through SETUP, ACCESS (WAIT_CYCLES wait states),
// CAPTURE and DONE; a read delivers the word on MDR_D with a Load_MDR pulse.
// Optional build macro MEM_READY_HS_EN: ACCESS also waits for Mem_Ready.
// Ports:
//   Clk, Reset_n (async, active-low)
//   Start, Rd_Wr, Addr, Wr_Data       request, latched in IDLE
//   Mem_Data_In, Mem_Ready            SRAM read data / ready
//   Mem_Addr, Mem_Data_Out, Data_Drive, Mem_CE_n, Mem_OE_n, Mem_WE_n
//   MDR_D, Load_MDR                   MDR data and load pulse
//   Busy, Done                        status
module mem_xfer_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic        Rd_Wr,
    input  logic [15:0] Addr,
    input  logic [15:0] Wr_Data,
    input  logic [15:0] Mem_Data_In,
    input  logic        Mem_Ready,
    output logic [15:0] Mem_Addr,
    output logic [15:0] Mem_Data_Out,
    output logic        Data_Drive,
    output logic        Mem_CE_n,
    output logic        Mem_OE_n,
    output logic        Mem_WE_n,
    output logic [15:0] MDR_D,
    output logic        Load_MDR,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t     state, nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       rd, rd_nxt;
    logic       accept;
    logic       acc_exit;

    // Next-cycle output values; registered so every output is glitch-free.
    logic ce_nxt, oe_nxt, we_nxt, drive_nxt, load_nxt, busy_nxt, done_nxt;

    assign accept = (state == S_IDLE) && Start;

`ifdef MEM_READY_HS_EN
    assign acc_exit = (cnt == 4'd0) && Mem_Ready;
`else
    // Mem_Ready has no effect in this build.
    assign acc_exit = (cnt == 4'd0) && (Mem_Ready | 1'b1);
`endif

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        unique case (state)
            S_IDLE: begin
                if (Start) nxt = S_SETUP;
            end
            S_SETUP: begin
                nxt     = S_ACCESS;
                cnt_nxt = CNT_INIT;
            end
            S_ACCESS: begin
                if (acc_exit) nxt = S_CAPTURE;
                // Counter saturates at 0 while waiting on Mem_Ready.
                else if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
            end
            S_CAPTURE: nxt = S_DONE;
            S_DONE:    nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_nxt    = accept ? Rd_Wr : rd;
        busy_nxt  = (nxt == S_SETUP) || (nxt == S_ACCESS)
                 || (nxt == S_CAPTURE);
        ce_nxt    = !busy_nxt;
        oe_nxt    = !((nxt == S_ACCESS) && rd_nxt);
        we_nxt    = !((nxt == S_ACCESS) && !rd_nxt);
        drive_nxt = ((nxt == S_ACCESS) || (nxt == S_CAPTURE)) && !rd_nxt;
        load_nxt  = (nxt == S_CAPTURE) && rd_nxt;
        done_nxt  = (nxt == S_DONE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            rd           <= 1'b0;
            Mem_Addr     <= 16'h0000;
            Mem_Data_Out <= 16'h0000;
            MDR_D        <= 16'h0000;
            Mem_CE_n     <= 1'b1;
            Mem_OE_n     <= 1'b1;
            Mem_WE_n     <= 1'b1;
            Data_Drive   <= 1'b0;
            Load_MDR     <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
        end else begin
            state      <= nxt;
            cnt        <= cnt_nxt;
            rd         <= rd_nxt;
            Mem_CE_n   <= ce_nxt;
            Mem_OE_n   <= oe_nxt;
            Mem_WE_n   <= we_nxt;
            Data_Drive <= drive_nxt;
            Load_MDR   <= load_nxt;
            Busy       <= busy_nxt;
            Done       <= done_nxt;
            if (accept) begin
                Mem_Addr     <= Addr;
                Mem_Data_Out <= Wr_Data;
            end
            // Read data is captured on the ACCESS exit edge.
            if ((state == S_ACCESS) && acc_exit && rd)
                MDR_D <= Mem_Data_In;
        end
    end

endmodule

// File: doc/mem_xfer_ctrl.md
# mem_xfer_ctrl

Memory transfer sequencer for the SLC-3 datapath; sits directly upstream of the MDR register (reg_16) and drives its `D`/`Load` pair. It accepts a single read or write request, runs the SRAM control strobes through setup, access (wait states) and hold phases, and for reads delivers the fetched word together with a one-cycle MDR load pulse. It reports `Busy` while a transfer is in flight and pulses `Done` on completion.

## Interface
- `WAIT_CYCLES`, default 2: ACCESS-phase length in cycles; legal range 1..15.
- `Clk` in 1: system clock; all state changes on the rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Start` in 1: transfer request; sampled only in IDLE.
- `Rd_Wr` in 1: 1 = read, 0 = write; latched with `Start`.
- `Addr` in 16: transfer address; latched with `Start`.
- `Wr_Data` in 16: write data; latched with `Start`.
- `Mem_Data_In` in 16: SRAM read data.
- `Mem_Ready` in 1: SRAM ready; used only with `MEM_READY_HS_EN`.
- `Mem_Addr` out 16: registered SRAM address.
- `Mem_Data_Out` out 16: registered SRAM write data.
- `Data_Drive` out 1: 1 while the write bus driver is enabled.
- `Mem_CE_n`, `Mem_OE_n`, `Mem_WE_n` out 1 each: active-low SRAM strobes.
- `MDR_D` out 16: data to the MDR register's `D` input.
- `Load_MDR` out 1: MDR load pulse.
- `Busy` out 1: transfer in progress.
- `Done` out 1: one-cycle completion pulse.

## Operation
- Reset values:
  - `Mem_CE_n`, `Mem_OE_n`, `Mem_WE_n` = 1.
  - `Mem_Addr`, `Mem_Data_Out`, `MDR_D` = 16'h0000.
  - `Data_Drive`, `Load_MDR`, `Busy`, `Done` = 0.
  - State = IDLE; wait counter = 0.
- All outputs are registered and decoded from state.
- FSM states: IDLE, SETUP, ACCESS, CAPTURE, DONE.
- **IDLE**
  - `Start`=1 at an edge latches `Addr` into `Mem_Addr`, `Wr_Data` into `Mem_Data_Out`, and `Rd_Wr`.
  - Transition to SETUP.
- **SETUP** (1 cycle)
  - `Mem_CE_n`=0; `Mem_OE_n`=`Mem_WE_n`=1.
  - Wait counter loads `WAIT_CYCLES-1`.
  - Transition to ACCESS.
- **ACCESS**
  - `Mem_CE_n`=0.
  - Read: `Mem_OE_n`=0.
  - Write: `Mem_WE_n`=0 and `Data_Drive`=1.
  - Counter decrements each cycle.
  - Exit to CAPTURE on the edge where counter==0 (see Configuration).
  - Read: the exit edge captures `Mem_Data_In` into `MDR_D`.
- **CAPTURE** (1 cycle)
  - `Mem_CE_n`=0; `Mem_OE_n`=`Mem_WE_n`=1.
  - Read: `Load_MDR`=1, so the MDR loads `MDR_D` at the end of this cycle.
  - Write: `Data_Drive` stays 1 (data hold); `Load_MDR`=0.
  - Transition to DONE.
- **DONE** (1 cycle)
  - All strobes inactive; `Done`=1; `Busy`=0.
  - Transition to IDLE.
- `Busy`=1 in SETUP, ACCESS and CAPTURE.
- `Start` is ignored outside IDLE, including in DONE. A request is never queued.
- Changes to `Addr`, `Wr_Data` or `Rd_Wr` after the latch edge have no effect on the current transfer.
- `MDR_D` holds its last read value through writes and idle periods.
- A write never asserts `Load_MDR`.
- `Mem_OE_n` and `Mem_WE_n` are never both 0.
- `Data_Drive` is never 1 while `Mem_OE_n`=0.

## Timing
- Edge 0 = the edge that samples `Start`. With W = `WAIT_CYCLES`:
  - SETUP occupies cycle 1.
  - ACCESS occupies cycles 2..W+1.
  - CAPTURE occupies cycle W+2, with `Load_MDR` high.
  - DONE occupies cycle W+3.
- Start to `Done` = W+3 cycles.
- Back-to-back: `Start` held high is next accepted in the first IDLE cycle after DONE. Issue rate is one transfer per W+4 cycles.
- W=1: ACCESS lasts exactly one cycle.
- `Reset_n` low at any point, mid-transfer included:
  - Outputs go to reset values immediately, without waiting for a clock.
  - Any pending `Load_MDR` or `Done` is cancelled.
  - No partial write strobe remains asserted.
- After `Reset_n` deasserts, the first `Start` is accepted on the first rising edge.

## Configuration
- `MEM_READY_HS_EN` defined:
  - ACCESS exits only on an edge where counter==0 and `Mem_Ready`==1.
  - Otherwise ACCESS holds, with strobes steady and the counter saturated at 0.
  - `WAIT_CYCLES` acts as the minimum access length.
  - There is no timeout.
- `MEM_READY_HS_EN` undefined: `Mem_Ready` is ignored and ACCESS is exactly `WAIT_CYCLES` cycles.

## Test plan
- **Read, W=2:** `Mem_Data_In`=16'hBEEF, `Start` with `Rd_Wr`=1, `Addr`=16'h3000.
  - `Mem_Addr`=16'h3000 from cycle 1.
  - `Mem_OE_n`=0 in cycles 2–3.
  - `Load_MDR`=1 with `MDR_D`=16'hBEEF in cycle 4.
  - `Done`=1 in cycle 5.
- **Write, W=2:** `Addr`=16'h0010, `Wr_Data`=16'h1234.
  - `Mem_WE_n`=0 and `Data_Drive`=1 in cycles 2–3.
  - `Data_Drive`=1 in cycle 4.
  - `Load_MDR` never asserted; `MDR_D` unchanged.
  - `Done` in cycle 5.
- **Busy request and back-to-back:**
  - Pulse `Start` with a different address while `Busy` → ignored; `Mem_Addr` unchanged.
  - `Start` held high → second transfer's SETUP at cycle W+5, not earlier.
- **Reset mid-transfer:** assert `Reset_n`=0 during a write ACCESS.
  - `Mem_WE_n`=1, `Mem_CE_n`=1 and `Busy`=0 with no clock edge.
  - No `Done` or `Load_MDR` afterwards.
- **Handshake (`MEM_READY_HS_EN`), W=1:** hold `Mem_Ready`=0 for 5 cycles, then raise it with `Mem_Data_In`=16'h00A5.
  - ACCESS lasts 6 cycles.
  - Then `Load_MDR` with `MDR_D`=16'h00A5.
- **Boundary W=1, no macro:** read completes with `Done` at cycle 4.
